// File: rtl/adder_tree_pkg.sv
// Shared types and width helpers for the pipelined adder tree.
// Also holds the accumulator FSM encoding.
package adder_tree_pkg;

   typedef enum logic [0:0] {
      ACC_IDLE = 1'b0,
      ACC_RUN  = 1'b1
   } acc_state_t;

   function automatic int calc_levels(input int num_inputs);
      return $clog2(num_inputs);
   endfunction

   function automatic int calc_sum_width(input int adder_width, input int num_inputs,
                                         input int accumulate, input int acc_extra);
      return adder_width + $clog2(num_inputs) + ((accumulate != 0) ? acc_extra : 0);
   endfunction

endpackage

// File: rtl/adder_tree_pipelined_if.sv
// Lane-parallel producer side and single-lane result side of the adder tree.
// No backpressure exists, so every signal flows in one direction only.
interface adder_tree_pipelined_if #(
   parameter int ADDER_WIDTH = 20,
   parameter int NUM_INPUTS  = 8,
   parameter int SUM_WIDTH   = 23
);
   logic                              in_valid;
   logic                              in_last;
   logic [NUM_INPUTS*ADDER_WIDTH-1:0] in_data;
   logic                              out_valid;
   logic [SUM_WIDTH-1:0]              out_sum;

   modport master (
      output in_valid, in_last, in_data,
      input  out_valid, out_sum
   );

   modport slave (
      input  in_valid, in_last, in_data,
      output out_valid, out_sum
   );
endinterface

// File: rtl/adder_tree_stage.sv
// One registered tree level: adds adjacent lane pairs, widening each result by one bit.
// Data holds when the stage-valid is low so bubbles never disturb stored sums.
module adder_tree_stage #(
   parameter int IN_WIDTH = 20,
   parameter int PAIRS    = 4,
   parameter int SIGNED   = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   input  logic                            in_last,
   input  logic [2*PAIRS*IN_WIDTH-1:0]     in_data,
   output logic                            out_valid,
   output logic                            out_last,
   output logic [PAIRS*(IN_WIDTH+1)-1:0]   out_data
);
   localparam int OUT_WIDTH = IN_WIDTH + 1;

   logic [PAIRS*OUT_WIDTH-1:0] w_sum;
   logic [PAIRS*OUT_WIDTH-1:0] r_data;
   logic                       r_valid;
   logic                       r_last;

   function automatic logic [OUT_WIDTH-1:0] ext(input logic [IN_WIDTH-1:0] x);
      if (SIGNED != 0) begin
         return {x[IN_WIDTH-1], x};
      end else begin
         return {1'b0, x};
      end
   endfunction

   // Pairwise sums: element j comes from input elements 2j and 2j+1.
   always_comb begin
      w_sum = '0;
      for (int j = 0; j < PAIRS; j++) begin
         w_sum[j*OUT_WIDTH +: OUT_WIDTH] = ext(in_data[(2*j)*IN_WIDTH +: IN_WIDTH])
                                         + ext(in_data[(2*j+1)*IN_WIDTH +: IN_WIDTH]);
      end
   end

   // Level register with valid/last shift alongside the data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= in_valid;
         r_last  <= in_last & in_valid;
         if (in_valid) begin
            r_data <= w_sum;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign out_data  = r_data;

endmodule

// File: rtl/adder_tree_pipelined.sv
// Pipelined binary adder tree with one register per level and an optional
// multi-beat accumulator that takes the place of the output register.
module adder_tree_pipelined
   import adder_tree_pkg::*;
#(
   parameter int ADDER_WIDTH = 20,
   parameter int NUM_INPUTS  = 8,
   parameter int SIGNED      = 0,
   parameter int ACCUMULATE  = 0,
   parameter int ACC_EXTRA   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   adder_tree_pipelined_if.slave  bus
);
   localparam int LEVELS    = calc_levels(NUM_INPUTS);
   localparam int SUM_WIDTH = calc_sum_width(ADDER_WIDTH, NUM_INPUTS, ACCUMULATE, ACC_EXTRA);
   localparam int ROOT_W    = ADDER_WIDTH + LEVELS;

   logic [NUM_INPUTS*ADDER_WIDTH-1:0] r_data0;
   logic                              r_valid0;
   logic                              r_last0;

   logic [ROOT_W-1:0]    w_root;
   logic                 w_root_valid;
   logic                 w_root_last;
   logic [SUM_WIDTH-1:0] w_root_ext;

   acc_state_t           r_state;
   acc_state_t           w_state_nxt;
   logic [SUM_WIDTH-1:0] r_acc;
   logic [SUM_WIDTH-1:0] w_acc_nxt;
   logic                 w_publish;
   logic                 r_out_valid;
   logic [SUM_WIDTH-1:0] r_out_sum;

   // Stage 0: capture the raw lanes; last is only meaningful with valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid0 <= 1'b0;
         r_last0  <= 1'b0;
         r_data0  <= '0;
      end else begin
         r_valid0 <= bus.in_valid;
         r_last0  <= bus.in_last & bus.in_valid;
         if (bus.in_valid) begin
            r_data0 <= bus.in_data;
         end
      end
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int IN_W  = ADDER_WIDTH + k - 1;
      localparam int PAIRS = NUM_INPUTS >> k;

      logic [2*PAIRS*IN_W-1:0]     w_in_data;
      logic                        w_in_valid;
      logic                        w_in_last;
      logic [PAIRS*(IN_W+1)-1:0]   w_out_data;
      logic                        w_out_valid;
      logic                        w_out_last;

      if (k == 1) begin : g_first
         assign w_in_data  = r_data0;
         assign w_in_valid = r_valid0;
         assign w_in_last  = r_last0;
      end else begin : g_next
         assign w_in_data  = g_lvl[k-1].w_out_data;
         assign w_in_valid = g_lvl[k-1].w_out_valid;
         assign w_in_last  = g_lvl[k-1].w_out_last;
      end

      adder_tree_stage #(
         .IN_WIDTH (IN_W),
         .PAIRS    (PAIRS),
         .SIGNED   (SIGNED)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (w_in_valid),
         .in_last   (w_in_last),
         .in_data   (w_in_data),
         .out_valid (w_out_valid),
         .out_last  (w_out_last),
         .out_data  (w_out_data)
      );
   end

   assign w_root       = g_lvl[LEVELS].w_out_data;
   assign w_root_valid = g_lvl[LEVELS].w_out_valid;
   assign w_root_last  = g_lvl[LEVELS].w_out_last;

   if (SIGNED != 0) begin : g_sext
      assign w_root_ext = SUM_WIDTH'($signed(w_root));
   end else begin : g_zext
      assign w_root_ext = SUM_WIDTH'(w_root);
   end

   // Next-state and publish decision; without accumulation every root beat publishes.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_publish   = 1'b0;
      if (w_root_valid) begin
         if (ACCUMULATE == 0) begin
            w_acc_nxt = w_root_ext;
            w_publish = 1'b1;
         end else begin
            case (r_state)
               ACC_IDLE: begin
                  w_acc_nxt   = w_root_ext;
                  w_publish   = w_root_last;
                  w_state_nxt = w_root_last ? ACC_IDLE : ACC_RUN;
               end
               ACC_RUN: begin
                  w_acc_nxt   = r_acc + w_root_ext;
                  w_publish   = w_root_last;
                  w_state_nxt = w_root_last ? ACC_IDLE : ACC_RUN;
               end
               default: begin
                  w_acc_nxt   = w_root_ext;
                  w_publish   = 1'b0;
                  w_state_nxt = ACC_IDLE;
               end
            endcase
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Accumulator, FSM state and the published result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ACC_IDLE;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_out_valid <= w_publish;
         if (w_publish) begin
            r_out_sum <= w_acc_nxt;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;

endmodule

// File: doc/adder_tree_pipelined.md
# adder_tree_pipelined

Parametrised, fully pipelined binary adder tree with a valid-qualified data path and an optional multi-beat accumulator. It reduces NUM_INPUTS lanes of ADDER_WIDTH bits to one sum, with one register stage per tree level. It generalises the fixed 8-input, 3-level tree to any power-of-two lane count. It sits between a lane-parallel producer (e.g. a MAC array) and a single-lane consumer, and carries no backpressure.

## Interface
- ADDER_WIDTH, 20: width of each input lane.
- NUM_INPUTS, 8: lane count; power of two, 2..64.
- SIGNED, 0: 1 = two's-complement lanes (sign-extend at every widening); 0 = zero-extend.
- ACCUMULATE, 0: 1 = sum successive beats until in_last; 0 = every beat is its own result, and in_last is ignored.
- ACC_EXTRA, 8: extra accumulator bits; only meaningful when ACCUMULATE=1.
- Derived LEVELS = log2(NUM_INPUTS).
- Derived SUM_WIDTH = ADDER_WIDTH + LEVELS + (ACCUMULATE ? ACC_EXTRA : 0).
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  beat present on in_data this cycle.
- in_last  in  1  final beat of an accumulation packet; qualified by in_valid.
- in_data  in  NUM_INPUTS*ADDER_WIDTH  lane i occupies [i*ADDER_WIDTH +: ADDER_WIDTH].
- out_valid  out  1  one-cycle pulse; out_sum holds a result.
- out_sum  out  SUM_WIDTH  result, extended per SIGNED.

## Operation
- Stage 0 registers in_data and in_valid/in_last.
- Level k (1..LEVELS) adds adjacent pairs from level k-1. Result width is ADDER_WIDTH+k. The result is registered.
- Lane pairing is fixed: element j of level k = elements 2j and 2j+1 of level k-1.
- Valid/last travel down a shift pipeline alongside the data. Data registers load only when their stage-valid is 1 and otherwise hold. Bubbles (in_valid=0) pass through untouched.
- Tree arithmetic is exact; no overflow is possible inside the tree.
- ACCUMULATE=0: the tree root is registered into out_sum together with its valid.
- ACCUMULATE=1: a two-state FSM drives the accumulator.
  - IDLE: a valid root beat loads acc = root (extended). If last=1, publish acc and stay in IDLE; otherwise go to ACCUM.
  - ACCUM: a valid beat sets acc = acc + root. If last=1, publish and return to IDLE.
  - Invalid cycles leave the state and acc unchanged.
  - Publish means out_sum <= new acc value and out_valid <= 1 for exactly one cycle.
  - Accumulator overflow wraps modulo 2^SUM_WIDTH. No saturation and no flag.
- Reset (rst_n=0 at a clock edge) clears all valid bits, all data registers, acc, out_sum and out_valid to 0, and forces FSM=IDLE.
  - Reset mid-packet or mid-pipeline discards every partial result. No out_valid follows from pre-reset beats.
- in_last with in_valid=0 is ignored.

## Timing
- Latency from in_valid sampled at edge t to out_valid high after edge t+LEVELS+1, in both modes. The accumulator replaces the output register, so there is no extra stage.
- Throughput: one beat per cycle; back-to-back packets need no gap.
- A packet's last beat and the next packet's first beat may be consecutive. The next packet's beat loads acc fresh (IDLE path).
- Reset values: out_valid=0, out_sum=0. Both remain 0 until the first valid beat emerges after LEVELS+1 cycles.

## Structure
- Package adder_tree_pkg:
  - clog2-based function for LEVELS.
  - function for SUM_WIDTH.
  - FSM enum acc_state_t {ACC_IDLE, ACC_RUN}.
- Sub-module adder_tree_stage: one registered level with parameters IN_WIDTH, PAIRS, SIGNED.
  - Ports: clk, rst_n, in_valid, in_last, packed in_data, out_valid, out_last, packed out_data.
  - The top instantiates it LEVELS times from a generate loop.
- The accumulator/FSM lives in the top.

## Test plan
- Defaults, ACCUMULATE=0: lanes 1..8, single valid beat -> out_valid pulse 4 cycles later, out_sum=36. Lanes all 0xFFFFF -> out_sum=0x7FFFF8.
- SIGNED=1, W=20: lanes all 0xFFFFF (-1) -> out_sum=-8 sign-extended in 23 bits (0x7FFFF8 reinterpreted as signed).
- Streaming: 10 consecutive beats with lane0=n and others 0, in_valid pattern 1101111011 -> 8 pulses in the same order and spacing, values matching the valid n.
- ACCUMULATE=1: 3 beats of all-lanes=1, in_last on beat 3 -> exactly one out_valid with out_sum=24; no pulse on beats 1-2. An immediately following single-beat packet gives 8 one cycle later.
- Wrap: ACC_EXTRA=0, W=4, N=2, lanes 15+15 for 2 beats -> out_sum=60 mod 32 = 28.
- Reset: drop rst_n for 1 cycle while beat 2 of 3 is mid-pipeline -> no out_valid from that packet. Outputs read 0 after the reset edge, and a fresh packet afterwards sums correctly.
